// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter.
// Producer indices fix the round-robin search order.
package cdb_arbiter_pkg;

  localparam int NUM_FU = 6;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 3;
  localparam int PTR_W  = 3;

  localparam logic [SRC_W-1:0] FU_ALU    = 3'd0;
  localparam logic [SRC_W-1:0] FU_BRANCH = 3'd1;
  localparam logic [SRC_W-1:0] FU_LD_STR = 3'd2;
  localparam logic [SRC_W-1:0] FU_MUL    = 3'd3;
  localparam logic [SRC_W-1:0] FU_DIV    = 3'd4;
  localparam logic [SRC_W-1:0] FU_ACCEL  = 3'd5;

  // One CDB beat. reg_id/data line up with the command buffer entry so
  // the ROB capture port can map one onto the other field by field.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  reg_id;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } cdb_bus_t;

  // Round-robin pointer after granting producer g: the one just past it,
  // wrapping from the last producer back to alu.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    return (g == FU_ACCEL) ? '0 : PTR_W'(g + 1'b1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle.
//
// Handshake: a producer raises req_valid[i] with req_tag/req_data for its
// lane and holds all three stable until a clock edge where req_ready[i] is
// also high; that edge is the transfer. req_ready[i] never depends on
// req_valid[i]. The CDB side has no ready: a beat with cdb_valid=1 is
// consumed in the cycle it appears.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]        req_valid;
  logic [NUM_FU*TAG_W-1:0]  req_tag;
  logic [NUM_FU*DATA_W-1:0] req_data;
  logic [NUM_FU-1:0]        req_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [SRC_W-1:0]         cdb_src;
  logic                     busy;
  logic [PTR_W-1:0]         dbg_rr_ptr;

  // Producers and the CDB consumer.
  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, busy, dbg_rr_ptr
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, busy, dbg_rr_ptr
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// i_ptr (wrapping modulo N) wins. o_grant is one-hot, or zero with no request.
module cdb_arbiter_rr_arbiter #(
  parameter int N     = 6,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  localparam int DW = PTR_W + 1;

  // Search distance of requester i from the pointer, in 0..N-1.
  function automatic logic [DW-1:0] dist_of(input int i, input logic [PTR_W-1:0] p);
    logic [DW-1:0] wi;
    logic [DW-1:0] wp;
    wi = DW'(i);
    wp = {1'b0, p};
    return (wi >= wp) ? (wi - wp) : (wi + DW'(N) - wp);
  endfunction

  // Find the smallest distance among requesters, then grant the one at it.
  always_comb begin
    logic [DW-1:0] w_d;
    logic [DW-1:0] w_best_d;
    logic          w_found;
    w_d      = '0;
    w_best_d = '1;
    w_found  = 1'b0;
    o_grant  = '0;
    for (int i = 0; i < N; i++) begin
      w_d = dist_of(i, i_ptr);
      if (i_req[i] && (!w_found || (w_d < w_best_d))) begin
        w_best_d = w_d;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      w_d = dist_of(i, i_ptr);
      o_grant[i] = w_found && i_req[i] && (w_d == w_best_d);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, a
// round-robin pick among occupied slots each cycle, and a registered CDB.
// Arbitration looks at slot state only, so a result always spends at least
// one cycle in its slot before it is broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  logic [NUM_FU-1:0] r_slot_valid;
  logic [TAG_W-1:0]  r_slot_tag  [NUM_FU];
  logic [DATA_W-1:0] r_slot_data [NUM_FU];
  logic [PTR_W-1:0]  r_rr_ptr;
  cdb_bus_t          r_cdb;

  logic              w_clear;
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_ready;
  logic [NUM_FU-1:0] w_load;
  logic              w_any_grant;
  logic [SRC_W-1:0]  w_gnt_idx;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [DATA_W-1:0] w_sel_data;

  assign w_clear = rst | flush;

  cdb_arbiter_rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (r_slot_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // A slot accepts when empty or being drained this cycle; nothing is
  // accepted while state is being cleared, so such a request is dropped.
  always_comb begin
    w_ready = '0;
    w_load  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_ready[i] = !w_clear && (!r_slot_valid[i] || w_grant[i]);
      w_load[i]  = bus.req_valid[i] && w_ready[i];
    end
  end

  // Mux the granted slot's contents and encode its index.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    w_gnt_idx  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_grant[i]) begin
        w_sel_tag  = r_slot_tag[i];
        w_sel_data = r_slot_data[i];
        w_gnt_idx  = SRC_W'(i);
      end
    end
  end

  assign w_any_grant = |w_grant;

  // Holding slots: refill wins over drain so a slot can turn over each cycle.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_slot_tag[i]  <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_load[i]) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_tag[i]   <= bus.req_tag[i*TAG_W +: TAG_W];
          r_slot_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // CDB register and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_cdb.valid  <= 1'b1;
      r_cdb.reg_id <= w_sel_tag;
      r_cdb.data   <= w_sel_data;
      r_cdb.src    <= w_gnt_idx;
      r_rr_ptr     <= next_ptr(w_gnt_idx);
    end else begin
      r_cdb.valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.cdb_valid  = r_cdb.valid;
  assign bus.cdb_tag    = r_cdb.reg_id;
  assign bus.cdb_data   = r_cdb.data;
  assign bus.cdb_src    = r_cdb.src;
  assign bus.busy       = |r_slot_valid;
  assign bus.dbg_rr_ptr = r_rr_ptr;

endmodule
